seg_scan_2c: RTL and testbench

//  Downstream consumer of the two's-complement-to-BCD stage. Latches its 16-bit BCD magnitude and sign bit.

---
 rtl/seg_pkg.sv | 37 +++
 rtl/bcd_to_seg.sv | 34 +++
 rtl/seg_scan_2c.sv | 147 ++++++++++++++
 tb/tb_seg_scan_2c.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : seg_pkg                                                           |
// | Brief  : Shared segment codes, slot FSM states, and leading-digit helper.  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package seg_pkg;

    // Cathode codes {g,f,e,d,c,b,a}, active low
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ERR   = 7'h06;

    typedef enum logic {BLANK, DRIVE} slot_state_t;

    // Position of the most-significant nonzero nibble; 0 when the value is zero.
    function automatic logic [1:0] msd_pos(input logic [15:0] m);
        if (m[15:12] != 4'd0)     return 2'd3;
        else if (m[11:8] != 4'd0) return 2'd2;
        else if (m[7:4] != 4'd0)  return 2'd1;
        else                      return 2'd0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_to_seg.sv
// +----------------------------------------------------------------------------+
// | Module : bcd_to_seg                                                        |
// | Brief  : Combinational BCD nibble to active-low 7-segment code; >9 -> 'E'. |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_ERR;
        case (nib_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_ERR;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seg_scan_2c.sv
// +----------------------------------------------------------------------------+
// | Module : seg_scan_2c                                                       |
// | Brief  : 4-digit common-anode 7-seg scanner with sign and anti-ghost blank.|
// |          Define SEG_LZ_BLANK_EN to blank leading zeros.                    |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module seg_scan_2c
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] Din,
    input  logic        sign,
    input  logic        ld,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t CNT_LAST       = cnt_t'(REFRESH_DIV - 1);
    localparam cnt_t CNT_BLANK_LAST = cnt_t'(BLANK_CYC - 1);

    slot_state_t state_q, state_d;
    cnt_t        cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] shadow_mag_q, shadow_mag_d, disp_mag_q, disp_mag_d;
    logic        shadow_sign_q, shadow_sign_d, disp_sign_q, disp_sign_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        frame_q, frame_d;

    logic        slot_end, wrap;
    logic [3:0]  nib;
    logic [6:0]  nib_seg, digit_seg;

    bcd_to_seg u_dec (
        .nib_i (nib),
        .seg_o (nib_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BLANK;
            cnt_q         <= '0;
            idx_q         <= 2'd0;
            shadow_mag_q  <= 16'd0;
            shadow_sign_q <= 1'b0;
            disp_mag_q    <= 16'd0;
            disp_sign_q   <= 1'b0;
            an_q          <= 4'hF;
            seg_q         <= SEG_BLANK;
            frame_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shadow_mag_q  <= shadow_mag_d;
            shadow_sign_q <= shadow_sign_d;
            disp_mag_q    <= disp_mag_d;
            disp_sign_q   <= disp_sign_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            frame_q       <= frame_d;
        end
    end

    always_comb begin
        slot_end = (cnt_q == CNT_LAST);
        wrap     = slot_end && (idx_q == 2'd3);
        cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
        idx_d    = slot_end ? idx_q + 2'd1 : idx_q;
        frame_d  = wrap;

        state_d = state_q;
        case (state_q)
            BLANK:   if (cnt_q == CNT_BLANK_LAST) state_d = DRIVE;
            DRIVE:   if (slot_end)                state_d = BLANK;
            default: state_d = BLANK;
        endcase

        shadow_mag_d  = ld ? Din  : shadow_mag_q;
        shadow_sign_d = ld ? sign : shadow_sign_q;
        // A strobe coinciding with the wrap bypasses the shadow so it shows this frame
        disp_mag_d    = disp_mag_q;
        disp_sign_d   = disp_sign_q;
        if (wrap) begin
            disp_mag_d  = ld ? Din  : shadow_mag_q;
            disp_sign_d = ld ? sign : shadow_sign_q;
        end
    end

    // Outputs are built from next-state values so the registered pins track the FSM
    always_comb begin
        nib = 4'd0;
        case (idx_d)
            2'd0: nib = disp_mag_d[3:0];
            2'd1: nib = disp_mag_d[7:4];
            2'd2: nib = disp_mag_d[11:8];
            2'd3: nib = disp_mag_d[15:12];
            default: nib = 4'd0;
        endcase
    end

`ifdef SEG_LZ_BLANK_EN
    logic [1:0] msd;
    always_comb begin
        msd       = msd_pos(disp_mag_d);
        digit_seg = SEG_BLANK;
        if (disp_sign_d && ((msd == 2'd3 && idx_d == 2'd3) ||
                            (msd != 2'd3 && idx_d == msd + 2'd1)))
            digit_seg = SEG_MINUS;
        else if (idx_d <= msd)
            digit_seg = nib_seg;
    end
`else
    always_comb begin
        digit_seg = nib_seg;
        if (disp_sign_d && idx_d == 2'd3)
            digit_seg = SEG_MINUS;
    end
`endif

    always_comb begin
        an_d  = 4'hF;
        seg_d = SEG_BLANK;
        if (state_d == DRIVE) begin
            an_d  = ~(4'b0001 << idx_d);
            seg_d = digit_seg;
        end
    end

    assign an    = an_q;
    assign seg   = seg_q;
    assign dp    = 1'b1;
    assign frame = frame_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_2c.sv
// +----------------------------------------------------------------------------+
// | Module : tb_seg_scan_2c                                                    |
// | Brief  : Directed self-checking bench for seg_scan_2c (8-cycle slots).     |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_seg_scan_2c;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] Din;
    logic        sign;
    logic        ld;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame;

    int checks = 0;
    int errors = 0;

`ifdef SEG_LZ_BLANK_EN
    localparam logic [6:0] Z0 = 7'h40, Z1 = 7'h7F, Z2 = 7'h7F, Z3 = 7'h7F;
    localparam logic [6:0] A0 = 7'h40, A1 = 7'h79, A2 = 7'h3F, A3 = 7'h7F;
    localparam logic [6:0] B0 = 7'h00, B1 = 7'h24, B2 = 7'h79, B3 = 7'h7F;
    localparam logic [6:0] C0 = 7'h40, C1 = 7'h24, C2 = 7'h7F, C3 = 7'h7F;
    localparam logic [6:0] E0 = 7'h30, E1 = 7'h06, E2 = 7'h7F, E3 = 7'h7F;
`else
    localparam logic [6:0] Z0 = 7'h40, Z1 = 7'h40, Z2 = 7'h40, Z3 = 7'h40;
    localparam logic [6:0] A0 = 7'h40, A1 = 7'h79, A2 = 7'h40, A3 = 7'h3F;
    localparam logic [6:0] B0 = 7'h00, B1 = 7'h24, B2 = 7'h79, B3 = 7'h40;
    localparam logic [6:0] C0 = 7'h40, C1 = 7'h24, C2 = 7'h40, C3 = 7'h40;
    localparam logic [6:0] E0 = 7'h30, E1 = 7'h06, E2 = 7'h40, E3 = 7'h40;
`endif

    seg_scan_2c #(
        .REFRESH_DIV (8),
        .BLANK_CYC   (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .Din   (Din),
        .sign  (sign),
        .ld    (ld),
        .an    (an),
        .seg   (seg),
        .dp    (dp),
        .frame (frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Walks one 32-cycle frame from its first edge, checking every cycle;
    // optional ld strobes fire at the edge following iteration atA / atB.
    task automatic check_frame(input string tag,
                               input logic [6:0] e0, input logic [6:0] e1,
                               input logic [6:0] e2, input logic [6:0] e3,
                               input int atA, input logic [15:0] dA, input logic sA,
                               input int atB, input logic [15:0] dB, input logic sB);
        logic [6:0] exp_seg [4];
        logic [3:0] exp_an;
        logic [6:0] exp_s;
        int e, d;
        exp_seg = '{e0, e1, e2, e3};
        for (int c = 0; c < 32; c++) begin
            if (c == atA) begin
                ld = 1'b1; Din = dA; sign = sA;
            end else if (c == atB) begin
                ld = 1'b1; Din = dB; sign = sB;
            end else begin
                ld = 1'b0;
            end
            step();
            ld = 1'b0;
            e = c + 1;
            d = (e / 8) % 4;
            if ((e % 8) < 2) begin
                exp_an = 4'hF;
                exp_s  = 7'h7F;
            end else begin
                exp_an = ~(4'b0001 << d);
                exp_s  = exp_seg[d];
            end
            chk($sformatf("%s an e%0d", tag, e), {12'd0, an}, {12'd0, exp_an});
            chk($sformatf("%s seg e%0d", tag, e), {9'd0, seg}, {9'd0, exp_s});
            chk($sformatf("%s frame e%0d", tag, e), {15'd0, frame}, {15'd0, (e == 32)});
        end
    endtask

    initial begin
        rst_n = 1'b1; ld = 1'b0; Din = 16'd0; sign = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst an", {12'd0, an}, 16'h000F);
        chk("rst seg", {9'd0, seg}, 16'h007F);
        chk("rst dp", {15'd0, dp}, 16'h0001);
        chk("rst frame", {15'd0, frame}, 16'h0000);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        check_frame("zero", Z0, Z1, Z2, Z3, 5,  16'h0010, 1'b1, -1, 16'h0, 1'b0);
        check_frame("m10",  A0, A1, A2, A3, 10, 16'h0128, 1'b0, -1, 16'h0, 1'b0);
        check_frame("p128", B0, B1, B2, B3, 3,  16'h0005, 1'b0, 20, 16'h0020, 1'b0);
        check_frame("p20",  C0, C1, C2, C3, 31, 16'h0127, 1'b1, -1, 16'h0, 1'b0);
        check_frame("m127", 7'h78, 7'h24, 7'h79, 7'h3F, 31, 16'h00A3, 1'b0, -1, 16'h0, 1'b0);
        check_frame("pA3",  E0, E1, E2, E3, -1, 16'h0, 1'b0, -1, 16'h0, 1'b0);

        // Reset asserted mid-DRIVE must clear the pins without a clock edge
        repeat (4) step();
        chk("pre-rst an", {12'd0, an}, 16'h000E);
        chk("pre-rst seg", {9'd0, seg}, 16'h0030);
        #2 rst_n = 1'b0;
        #1;
        chk("async an", {12'd0, an}, 16'h000F);
        chk("async seg", {9'd0, seg}, 16'h007F);
        chk("async frame", {15'd0, frame}, 16'h0000);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        chk("rel e1 an", {12'd0, an}, 16'h000F);
        step();
        chk("rel e2 an", {12'd0, an}, 16'h000E);
        chk("rel e2 seg", {9'd0, seg}, 16'h0040);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
